// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR blocks: default widths, the serial MAC state
// encoding and the truncating multiply-accumulate used by both the tap chain
// and the serial engine.
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int unsigned FIR_N     = 32;
  localparam int unsigned FIR_TAPS  = 8;
  // Working width of the MAC helper; callers cast the result down to N bits,
  // which gives the per-product truncation and mod 2^N wrap (N <= 64).
  localparam int unsigned FIR_MAC_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_mac_state_t;

  function automatic logic [FIR_MAC_W-1:0] fir_mac(
    input logic [FIR_MAC_W-1:0] acc,
    input logic [FIR_MAC_W-1:0] b,
    input logic [FIR_MAC_W-1:0] x
  );
    return acc + b * x;
  endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// -----------------------------------------------------------------------------
// fir_serial_mac_if
// Sample input, coefficient write port and result output of fir_serial_mac.
//   x_in/x_valid/x_ready         : sample handshake (source -> engine)
//   coef_we/coef_addr/coef_data  : coefficient write, coef_err flags a drop
//   y_out/y_valid/y_ready        : result handshake (engine -> consumer)
// master = the environment driving samples/coefficients and consuming y,
// slave  = the filter engine.
// -----------------------------------------------------------------------------
interface fir_serial_mac_if #(
  parameter int unsigned N    = 32,
  parameter int unsigned TAPS = 8
);
  localparam int unsigned AW = $clog2(TAPS);

  logic [N-1:0]  x_in;
  logic          x_valid;
  logic          x_ready;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [N-1:0]  coef_data;
  logic          coef_err;
  logic [N-1:0]  y_out;
  logic          y_valid;
  logic          y_ready;

  modport master (
    output x_in, x_valid, coef_we, coef_addr, coef_data, y_ready,
    input  x_ready, coef_err, y_out, y_valid
  );

  modport slave (
    input  x_in, x_valid, coef_we, coef_addr, coef_data, y_ready,
    output x_ready, coef_err, y_out, y_valid
  );
endinterface

// File: rtl/fir_sample_ring.sv
// -----------------------------------------------------------------------------
// fir_sample_ring
// Circular sample history for the serial FIR engine.
//   clk, rst  : clock, asynchronous active-high reset (clears history, wr_ptr)
//   wr_en     : store wr_data at wr_ptr and advance the pointer
//   wr_data   : sample to store
//   rd_k      : tap index k
//   rd_data   : hist[(p - k) mod TAPS], p = slot most recently written
// -----------------------------------------------------------------------------
module fir_sample_ring #(
  parameter int unsigned N    = 32,
  parameter int unsigned TAPS = 8,
  localparam int unsigned AW  = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_k,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0]  hist [TAPS];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] last;
  logic [AW-1:0] rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
    end else if (wr_en) begin
      hist[wr_ptr] <= wr_data;
      wr_ptr       <= (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  // The pointer has already moved past the newest sample, so step back one.
  // On underflow the AW-bit sum last + TAPS - k lands in 0..TAPS-1 even when
  // the intermediate value wraps, so no wider arithmetic is needed.
  always_comb begin
    last   = (wr_ptr == '0) ? AW'(TAPS - 1) : wr_ptr - 1'b1;
    rd_idx = (last >= rd_k) ? last - rd_k : last + AW'(TAPS) - rd_k;
  end

  assign rd_data = hist[rd_idx];

endmodule

// File: rtl/fir_serial_mac.sv
// -----------------------------------------------------------------------------
// fir_serial_mac
// Time-multiplexed FIR: y[n] = sum_k b[k]*x[n-k], products truncated to N bits,
// sum mod 2^N. One MAC per cycle, TAPS+2 cycles per sample minimum.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fir_serial_mac_if.slave (sample in, coefficient write, y out)
//
//   state | meaning
//   IDLE  | x_ready=1, waiting for a sample; coefficient writes allowed
//   MAC   | one multiply-accumulate per cycle for k = 0..TAPS-1
//   OUT   | y_valid=1, y_out held until y_ready
// -----------------------------------------------------------------------------
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int unsigned N    = FIR_N,
  parameter int unsigned TAPS = FIR_TAPS
) (
  input logic             clk,
  input logic             rst,
  fir_serial_mac_if.slave bus
);

  localparam int unsigned AW = $clog2(TAPS);

  fir_mac_state_t state;
  logic [N-1:0]   coef [TAPS];
  logic [N-1:0]   acc;
  logic [N-1:0]   acc_next;
  logic [N-1:0]   hist_rd;
  logic [AW-1:0]  k;
  logic           accept;
  logic           last_tap;
  logic           coef_in_range;

  logic [N-1:0]   y_out_r;
  logic           y_valid_r;
  logic           x_ready_r;
  logic           coef_err_r;

  assign accept        = (state == IDLE) && bus.x_valid;
  assign last_tap      = (k == AW'(TAPS - 1));
  assign coef_in_range = (32'(bus.coef_addr) < TAPS);
  assign acc_next      = N'(fir_mac(FIR_MAC_W'(acc), FIR_MAC_W'(coef[k]),
                                    FIR_MAC_W'(hist_rd)));

  fir_sample_ring #(
    .N    (N),
    .TAPS (TAPS)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (bus.x_in),
    .rd_k    (k),
    .rd_data (hist_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      acc        <= '0;
      y_out_r    <= '0;
      y_valid_r  <= 1'b0;
      x_ready_r  <= 1'b1;
      coef_err_r <= 1'b0;
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else begin
      coef_err_r <= 1'b0;
      // A write in IDLE lands at the same edge as a sample accept, so the
      // first MAC cycle already sees the new coefficient.
      if (bus.coef_we) begin
        if ((state == IDLE) && coef_in_range) coef[bus.coef_addr] <= bus.coef_data;
        else coef_err_r <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.x_valid) begin
            k         <= '0;
            acc       <= '0;
            x_ready_r <= 1'b0;
            state     <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (last_tap) begin
            y_out_r   <= acc_next;
            y_valid_r <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (bus.y_ready) begin
            y_valid_r <= 1'b0;
            x_ready_r <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_ready  = x_ready_r;
  assign bus.y_valid  = y_valid_r;
  assign bus.y_out    = y_out_r;
  assign bus.coef_err = coef_err_r;

endmodule

// File: tb/tb_fir_serial_mac.sv
`timescale 1ns/1ps
module tb_fir_serial_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fir_serial_mac_if #(.N(32), .TAPS(8)) bus ();
  fir_serial_mac_if #(.N(32), .TAPS(6)) bus6 ();

  fir_serial_mac #(.N(32), .TAPS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fir_serial_mac #(.N(32), .TAPS(6)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (all called at a negedge) -------------
  task automatic set_coef(input int addr, input logic [31:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(addr);
    bus.coef_data = data;
    @(negedge clk);
    bus.coef_we   = 1'b0;
  endtask

  task automatic accept_sample(input logic [31:0] x, output int waited);
    waited = 0;
    while (!bus.x_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    bus.x_in    = x;
    bus.x_valid = 1'b1;
    @(negedge clk);
    bus.x_valid = 1'b0;
  endtask

  task automatic collect_y(output logic [31:0] y, output int lat);
    bus.y_ready = 1'b1;
    lat = 0;
    y   = 32'hDEAD_BEEF;
    for (int i = 1; i <= 60; i++) begin
      if (bus.y_valid) begin
        lat = i;
        y   = bus.y_out;
        break;
      end
      @(negedge clk);
    end
    if (lat != 0) @(negedge clk);
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors += 5;
    if (bus.x_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_x_ready: got %0b expected 1", bus.x_ready);
    end
    if (bus.y_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_y_valid: got %0b expected 0", bus.y_valid);
    end
    if (bus.y_out !== 32'h0) begin
      miscompares++; $display("FAIL reset_y_out: got %h expected 00000000", bus.y_out);
    end
    if (bus.coef_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_coef_err: got %0b expected 0", bus.coef_err);
    end
    if (bus6.x_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_x_ready_t6: got %0b expected 1", bus6.x_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_impulse();
    logic [31:0] exp_y [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
    logic [31:0] y;
    int lat, waited;
    for (int i = 0; i < 8; i++) set_coef(i, 32'(i + 1));
    vectors++;
    if (bus.coef_err !== 1'b0) begin
      miscompares++; $display("FAIL impulse_coef_err: got %0b expected 0", bus.coef_err);
    end
    for (int n = 0; n < 9; n++) begin
      accept_sample((n == 0) ? 32'd1 : 32'd0, waited);
      collect_y(y, lat);
      vectors++;
      if (y !== exp_y[n]) begin
        miscompares++; $display("FAIL impulse_y[%0d]: got %h expected %h", n, y, exp_y[n]);
      end
      if (n == 0) begin
        vectors++;
        if (lat !== 9) begin
          miscompares++; $display("FAIL impulse_latency: got %0d expected 9", lat);
        end
      end
    end
  endtask

  task automatic test_step_wrap();
    logic [31:0] exp_y [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'hFFFF_FFF8};
    logic [31:0] y;
    int lat, waited;
    for (int i = 0; i < 8; i++) set_coef(i, 32'd2);
    for (int n = 0; n < 4; n++) begin
      accept_sample(32'hFFFF_FFFF, waited);
      collect_y(y, lat);
      vectors++;
      if (y !== exp_y[n]) begin
        miscompares++; $display("FAIL step_y[%0d]: got %h expected %h", n, y, exp_y[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] y;
    logic [31:0] y_hold;
    int lat, waited;
    bit seen;
    accept_sample(32'd3, waited);
    bus.y_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.y_valid) seen = 1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL bp_y_valid_timeout: got 0 expected 1");
    end
    y_hold = bus.y_out;
    vectors++;
    if (y_hold !== 32'hFFFF_FFFE) begin
      miscompares++; $display("FAIL bp_y: got %h expected fffffffe", y_hold);
    end
    bus.x_in    = 32'h0000_1234;
    bus.x_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.y_valid !== 1'b1 || bus.y_out !== 32'hFFFF_FFFE || bus.x_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got y_valid=%0b y_out=%h x_ready=%0b expected 1 fffffffe 0",
                 c, bus.y_valid, bus.y_out, bus.x_ready);
      end
    end
    bus.y_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.x_ready !== 1'b1 || bus.y_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: got x_ready=%0b y_valid=%0b expected 1 0", bus.x_ready, bus.y_valid);
    end
    @(negedge clk);
    bus.x_valid = 1'b0;
    vectors++;
    if (bus.x_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_accept: got x_ready=%0b expected 0", bus.x_ready);
    end
    collect_y(y, lat);
    vectors += 2;
    if (y !== 32'h0000_2466) begin
      miscompares++; $display("FAIL bp_held_sample_y: got %h expected 00002466", y);
    end
    if (lat !== 9) begin
      miscompares++; $display("FAIL bp_latency: got %0d expected 9", lat);
    end
  endtask

  task automatic test_coef_guard();
    logic [31:0] y;
    int lat, waited;
    bit seen;
    // write during MAC
    accept_sample(32'd1, waited);
    bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 32'd5;
    @(negedge clk);
    bus.coef_we = 1'b0;
    vectors++;
    if (bus.coef_err !== 1'b1) begin
      miscompares++; $display("FAIL guard_mac_err: got %0b expected 1", bus.coef_err);
    end
    @(negedge clk);
    vectors++;
    if (bus.coef_err !== 1'b0) begin
      miscompares++; $display("FAIL guard_err_pulse: got %0b expected 0", bus.coef_err);
    end
    collect_y(y, lat);
    vectors++;
    if (y !== 32'h0000_2468) begin
      miscompares++; $display("FAIL guard_mac_y: got %h expected 00002468", y);
    end
    // write during OUT
    accept_sample(32'd0, waited);
    bus.y_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.y_valid) seen = 1;
      else @(negedge clk);
    end
    bus.coef_we = 1'b1; bus.coef_addr = 3'd1; bus.coef_data = 32'd9;
    @(negedge clk);
    bus.coef_we = 1'b0;
    vectors++;
    if (!seen || bus.coef_err !== 1'b1) begin
      miscompares++; $display("FAIL guard_out_err: got %0b (out_seen=%0b) expected 1", bus.coef_err, seen);
    end
    collect_y(y, lat);
    vectors++;
    if (y !== 32'h0000_2468) begin
      miscompares++; $display("FAIL guard_out_y: got %h expected 00002468", y);
    end
  endtask

  task automatic test_range_guard();
    logic [2:0] addrs [3] = '{3'd7, 3'd6, 3'd5};
    logic       exp_err [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      bus6.coef_we = 1'b1; bus6.coef_addr = addrs[i]; bus6.coef_data = 32'd9;
      @(negedge clk);
      bus6.coef_we = 1'b0;
      vectors++;
      if (bus6.coef_err !== exp_err[i]) begin
        miscompares++;
        $display("FAIL range_err_addr%0d: got %0b expected %0b", addrs[i], bus6.coef_err, exp_err[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mac();
    logic [31:0] y;
    int lat, waited;
    bit bad;
    accept_sample(32'd5, waited);
    repeat (3) @(negedge clk);   // k = 3 now
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.y_valid !== 1'b0 || bus.x_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mac_outputs: got y_valid=%0b x_ready=%0b expected 0 1", bus.y_valid, bus.x_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.y_valid !== 1'b0) bad = 1;
    end
    vectors++;
    if (bad) begin
      miscompares++; $display("FAIL rst_mac_no_emit: got y_valid=1 expected 0");
    end
    for (int i = 1; i < 8; i++) set_coef(i, 32'(i + 1));
    // b[0] is written in the same cycle as the impulse is accepted
    bus.x_in = 32'd1; bus.x_valid = 1'b1;
    bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 32'd1;
    @(negedge clk);
    bus.x_valid = 1'b0; bus.coef_we = 1'b0;
    vectors++;
    if (bus.coef_err !== 1'b0) begin
      miscompares++; $display("FAIL rst_simul_coef_err: got %0b expected 0", bus.coef_err);
    end
    for (int n = 0; n < 8; n++) begin
      if (n != 0) accept_sample(32'd0, waited);
      collect_y(y, lat);
      vectors++;
      if (y !== 32'(n + 1)) begin
        miscompares++; $display("FAIL rst_impulse_y[%0d]: got %h expected %h", n, y, 32'(n + 1));
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [31:0] y;
    logic [31:0] exp;
    int lat, waited;
    set_coef(0, 32'd1);
    for (int i = 1; i < 7; i++) set_coef(i, 32'd0);
    set_coef(7, 32'd1);
    for (int n = 1; n <= 12; n++) begin
      accept_sample(32'(n), waited);
      collect_y(y, lat);
      exp = (n <= 7) ? 32'(n) : 32'(n + n - 7);
      vectors++;
      if (y !== exp) begin
        miscompares++; $display("FAIL wrap_y[x=%0d]: got %0d expected %0d", n, y, exp);
      end
      vectors++;
      if (waited !== 0) begin
        miscompares++; $display("FAIL wrap_gap[x=%0d]: got %0d idle cycles expected 0", n, waited);
      end
    end
  endtask

  initial begin
    bus.x_in = '0;  bus.x_valid = 1'b0;  bus.coef_we = 1'b0;
    bus.coef_addr = '0;  bus.coef_data = '0;  bus.y_ready = 1'b1;
    bus6.x_in = '0; bus6.x_valid = 1'b0; bus6.coef_we = 1'b0;
    bus6.coef_addr = '0; bus6.coef_data = '0; bus6.y_ready = 1'b1;

    test_reset();
    test_impulse();
    test_step_wrap();
    test_backpressure();
    test_coef_guard();
    test_range_guard();
    test_reset_mid_mac();
    test_back_to_back_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
